nearest_hit_scheduler: RTL and testbench
========================================

// Module: nearest_hit_scheduler
// PURPOSE
//  Per-ray triangle sweep sequencer; sits directly upstream of the intersection control unit and consumes its ready/code/t.
//  Accepts one ray, reads triangles 0..tri_count-1 from triangle memory and launches one intersection test per triangle.
//  Tracks the nearest valid hit (smallest t) and its index; returns one hit record per ray to the shading stage.
// PARAMETERS
//  IDX_W   16   triangle index / count width
//  START_HOLD 2 cycles isect_start is held high per test (>=2 required by CU edge detect)
// PORTS
//  clock        in   1        system clock
//  reset        in   1        synchronous, active-high
//  ray_valid    in   1        ray_in valid
//  ray_ready    out  1        block idle, ray accepted when ray_valid&&ray_ready
//  ray_in       in   ray      ray (start, dir) from ray generator
//  tri_count    in   IDX_W    triangles in scene, sampled at ray accept
//  tri_rd_en    out  1        triangle memory read strobe
//  tri_addr     out  IDX_W    triangle index to read
//  tri_v1/v2/v3 in   point    read data, valid 1 cycle after tri_rd_en
//  isect_start  out  1        test launch; CU detects rising edge
//  isect_ray    out  ray      registered ray, stable for whole sweep
//  isect_v1/v2/v3 out point   registered vertices, stable for whole test
//  isect_ready  in   1        CU test complete
//  isect_code   in   2        1 = hit, t valid; else miss
//  isect_t      in   fixed    hit distance (Q4.28)
//  hit_valid    out  1        result available, held until hit_accept
//  hit_accept   in   1        consumer takes result
//  hit_found    out  1        at least one triangle hit
//  hit_t        out  fixed    nearest t (0 when !hit_found)
//  hit_idx      out  IDX_W    index of nearest triangle (0 when !hit_found)
// BEHAVIOUR
//  Reset: state IDLE, ray_ready=1, all other outputs 0 (incl. isect_start, vertices, ray). Reset mid-sweep aborts; no result emitted.
//  FSM: IDLE -> FETCH (tri_rd_en=1, tri_addr=idx) -> CAPTURE (latch tri_v* into isect_v*) -> START (isect_start=1 for START_HOLD cycles)
//       -> WAIT (isect_start=0; sample isect_ready) -> UPDATE -> FETCH (idx+1) or DONE -> IDLE on hit_accept.
//  isect_ready is ignored during START: CU keeps ready high from the previous test until it sees the new edge.
//  isect_start is low >=1 cycle between tests (guaranteed by WAIT/UPDATE/FETCH/CAPTURE).
//  UPDATE: if isect_code==1 and (!found || isect_t < best_t) -> best_t=isect_t, best_idx=idx, found=1. Strict <: tie keeps lower index.
//  t compare unsigned 32-bit (CU only reports 0 < t < 2.0). Misses never modify best.
//  tri_count==0: IDLE -> DONE next cycle, hit_found=0, hit_t=0, hit_idx=0.
//  Last triangle: idx==tri_count-1 in UPDATE -> DONE; idx never wraps; counter is IDX_W+1 bits internally.
//  DONE: hit_valid=1, outputs stable until hit_accept; hit_accept in same cycle hit_valid rises is taken; ray_ready=0 until back in IDLE.
//  ray_valid while busy: ignored (not accepted). hit_accept outside DONE: ignored.
//  Per-triangle latency: 1 FETCH + 1 CAPTURE + START_HOLD + CU latency (3 cycles) + 1 UPDATE.
// CONFIGURATION
//  SHADOW_ANYHIT_EN: defined -> extra input shadow_mode (1 bit, sampled at ray accept); when set, first hit (code==1) goes straight to DONE
//   with that t/idx, remaining triangles skipped. Not defined -> port absent, full nearest-hit sweep always.
// STRUCTURE
//  definitions_pack: typedef hit_record {logic found; fixed t; logic [IDX_W-1:0] idx;}, localparam TRI_IDX_W=16.
//  math_pack: fixed compare helper reused; no new arithmetic.
//  Sub-module: nearest_hit_tracker (clear/update/compare registers for found, best_t, best_idx); FSM and memory interface stay in top.
// TESTING
//  1 tri, CU code=1 t=32'h08000000 -> hit_valid, found=1, hit_t=32'h08000000, hit_idx=0; exactly one isect_start rising edge.
//  3 tris, t=32'h10000000, 32'h04000000, 32'h0C000000 -> hit_t=32'h04000000, hit_idx=1.
//  tie: tris 0 and 2 both t=32'h06000000, tri 1 miss -> hit_idx=0; all misses -> found=0, t=0, idx=0.
//  tri_count=0 -> hit_valid 2 cycles after accept, found=0, tri_rd_en never asserted.
//  reset asserted in WAIT of tri 1 of 4 -> next cycle ray_ready=1, isect_start=0, no hit_valid; new ray sweeps from idx 0.
//  SHADOW_ANYHIT_EN, shadow_mode=1, 4 tris, tri 1 hits -> DONE with idx=1, tri_addr never reaches 2.

Source files
------------

// File: rtl/nearest_hit_scheduler_pkg.sv
// Shared types for the nearest-hit triangle sweep sequencer.
// Optional any-hit early exit is built when SHADOW_ANYHIT_EN is defined.
package nearest_hit_scheduler_pkg;

    localparam int TRI_IDX_W  = 16;
    localparam int IDX_W      = TRI_IDX_W;
    localparam int START_HOLD = 2;

    typedef logic [31:0] fixed;

    typedef struct packed {
        fixed x;
        fixed y;
        fixed z;
    } point;

    typedef struct packed {
        point start;
        point dir;
    } ray;

    typedef struct packed {
        logic                 found;
        fixed                 t;
        logic [TRI_IDX_W-1:0] idx;
    } hit_record;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [1:0] CODE_HIT = 2'd1;

    // CU only reports 0 < t < 2.0, so a plain unsigned compare orders hits
    function automatic logic fixed_lt(input fixed a, input fixed b);
        return a < b;
    endfunction

endpackage

// File: rtl/nearest_hit_scheduler_if.sv
// Ray in, triangle memory, intersection CU and hit-out bundle.
// shadow_mode exists only when SHADOW_ANYHIT_EN is defined.
interface nearest_hit_scheduler_if;
    import nearest_hit_scheduler_pkg::*;

    logic             ray_valid;
    logic             ray_ready;
    ray               ray_in;
    logic [IDX_W-1:0] tri_count;
`ifdef SHADOW_ANYHIT_EN
    logic             shadow_mode;
`endif

    logic             tri_rd_en;
    logic [IDX_W-1:0] tri_addr;
    point             tri_v1;
    point             tri_v2;
    point             tri_v3;

    logic             isect_start;
    ray               isect_ray;
    point             isect_v1;
    point             isect_v2;
    point             isect_v3;
    logic             isect_ready;
    logic [1:0]       isect_code;
    fixed             isect_t;

    logic             hit_valid;
    logic             hit_accept;
    logic             hit_found;
    fixed             hit_t;
    logic [IDX_W-1:0] hit_idx;

    modport master (
`ifdef SHADOW_ANYHIT_EN
        input  shadow_mode,
`endif
        input  ray_valid, ray_in, tri_count,
        output ray_ready,
        output tri_rd_en, tri_addr,
        input  tri_v1, tri_v2, tri_v3,
        output isect_start, isect_ray,
        output isect_v1, isect_v2, isect_v3,
        input  isect_ready, isect_code, isect_t,
        output hit_valid, hit_found, hit_t, hit_idx,
        input  hit_accept
    );

    modport slave (
`ifdef SHADOW_ANYHIT_EN
        output shadow_mode,
`endif
        output ray_valid, ray_in, tri_count,
        input  ray_ready,
        input  tri_rd_en, tri_addr,
        output tri_v1, tri_v2, tri_v3,
        input  isect_start, isect_ray,
        input  isect_v1, isect_v2, isect_v3,
        output isect_ready, isect_code, isect_t,
        input  hit_valid, hit_found, hit_t, hit_idx,
        output hit_accept
    );

endinterface

// File: rtl/nearest_hit_scheduler_tracker.sv
// Best-hit register: cleared per ray, replaced only by a strictly nearer hit.
// Ties keep the earlier (lower) triangle index.
module nearest_hit_tracker
    import nearest_hit_scheduler_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic             i_hit,
    input  fixed             i_t,
    input  logic [IDX_W-1:0] i_idx,
    output hit_record        o_best
);

    hit_record r_best;
    logic      w_take;

    assign w_take = i_update && i_hit &&
                    (!r_best.found || fixed_lt(i_t, r_best.t));

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_best <= '0;
        end else if (w_take) begin
            r_best.found <= 1'b1;
            r_best.t     <= i_t;
            r_best.idx   <= i_idx;
        end
    end

    assign o_best = r_best;

endmodule

// File: rtl/nearest_hit_scheduler.sv
// Per-ray triangle sweep: fetch, launch CU test, keep nearest hit.
// SHADOW_ANYHIT_EN adds shadow_mode: first hit ends the sweep.
module nearest_hit_scheduler
    import nearest_hit_scheduler_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    nearest_hit_scheduler_if.master bus
);

    localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

    state_t         r_state;
    state_t         w_next;
    logic [IDX_W:0] r_idx;
    logic [IDX_W:0] r_count;
    logic [3:0]     r_hold;
    ray             r_ray;
    point           r_v1;
    point           r_v2;
    point           r_v3;
    logic [1:0]     r_code;
    fixed           r_t;
    hit_record      w_best;

    logic           w_accept;
    logic           w_last;
    logic           w_hit;
    logic           w_short;

    assign w_accept = (r_state == S_IDLE) && bus.ray_valid;
    assign w_last   = (r_idx + (IDX_W+1)'(1)) == r_count;
    assign w_hit    = (r_code == CODE_HIT);

`ifdef SHADOW_ANYHIT_EN
    logic r_shadow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= 1'b0;
        end else if (w_accept) begin
            r_shadow <= bus.shadow_mode;
        end
    end

    assign w_short = r_shadow && w_hit;
`else
    assign w_short = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ray_valid) begin
                    w_next = (bus.tri_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_START;
            S_START: begin
                if (r_hold == HOLD_LAST) w_next = S_WAIT;
            end
            // ready is stale from the previous test until the CU sees our edge
            S_WAIT: begin
                if (bus.isect_ready) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                w_next = (w_last || w_short) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                if (bus.hit_accept) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_hold  <= '0;
            r_ray   <= '0;
            r_v1    <= '0;
            r_v2    <= '0;
            r_v3    <= '0;
            r_code  <= '0;
            r_t     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ray   <= bus.ray_in;
                r_count <= {1'b0, bus.tri_count};
                r_idx   <= '0;
            end
            if (r_state == S_CAPTURE) begin
                r_v1 <= bus.tri_v1;
                r_v2 <= bus.tri_v2;
                r_v3 <= bus.tri_v3;
            end
            r_hold <= (r_state == S_START) ? r_hold + 4'd1 : 4'd0;
            if (r_state == S_WAIT && bus.isect_ready) begin
                r_code <= bus.isect_code;
                r_t    <= bus.isect_t;
            end
            if (r_state == S_UPDATE && !w_last) begin
                r_idx <= r_idx + (IDX_W+1)'(1);
            end
        end
    end

    nearest_hit_tracker u_tracker (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_update (r_state == S_UPDATE),
        .i_hit    (w_hit),
        .i_t      (r_t),
        .i_idx    (r_idx[IDX_W-1:0]),
        .o_best   (w_best)
    );

    assign bus.ray_ready   = (r_state == S_IDLE);
    assign bus.tri_rd_en   = (r_state == S_FETCH);
    assign bus.tri_addr    = bus.tri_rd_en ? r_idx[IDX_W-1:0] : '0;
    assign bus.isect_start = (r_state == S_START);
    assign bus.isect_ray   = r_ray;
    assign bus.isect_v1    = r_v1;
    assign bus.isect_v2    = r_v2;
    assign bus.isect_v3    = r_v3;
    assign bus.hit_valid   = (r_state == S_DONE);
    assign bus.hit_found   = w_best.found;
    assign bus.hit_t       = w_best.t;
    assign bus.hit_idx     = w_best.idx;

endmodule

// File: tb/tb_nearest_hit_scheduler.sv
// Directed bench: table of sweeps plus reset/handshake corner sequences.
// Triangle memory returns its index in v1.x so the CU model can pick code/t.
module tb_nearest_hit_scheduler;
    import nearest_hit_scheduler_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nearest_hit_scheduler_if bus();

    nearest_hit_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int              n;
        logic [0:3][1:0] code;
        logic [0:3][31:0] t;
        logic            found;
        fixed            et;
        logic [15:0]     eidx;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    logic [1:0] cu_code [4];
    fixed       cu_t    [4];
    int   rd_total = 0;
    int   edge_total = 0;
    int   hv_total = 0;
    int   hi_total = 0;
    logic start_q = 1'b0;
    int   cu_cnt = 0;
    ray   tr;

    always @(posedge clock) begin
        if (bus.tri_rd_en) begin
            bus.tri_v1 <= {fixed'(bus.tri_addr), 32'h11, 32'h12};
            bus.tri_v2 <= {32'h21, 32'h22, 32'h23};
            bus.tri_v3 <= {32'h31, 32'h32, 32'h33};
        end
    end

    // CU: drops ready on a start edge, answers 3 cycles later
    always @(posedge clock) begin
        start_q <= bus.isect_start;
        if (reset) begin
            bus.isect_ready <= 1'b0;
            bus.isect_code  <= 2'd0;
            bus.isect_t     <= '0;
            cu_cnt          <= 0;
        end else if (bus.isect_start && !start_q) begin
            bus.isect_ready <= 1'b0;
            cu_cnt          <= 3;
        end else if (cu_cnt != 0) begin
            cu_cnt <= cu_cnt - 1;
            if (cu_cnt == 1) begin
                bus.isect_ready <= 1'b1;
                bus.isect_code  <= cu_code[bus.isect_v1.x[1:0]];
                bus.isect_t     <= cu_t[bus.isect_v1.x[1:0]];
            end
        end
    end

    always @(posedge clock) begin
        if (bus.tri_rd_en) rd_total <= rd_total + 1;
        if (bus.tri_rd_en && bus.tri_addr >= 16'd2) hi_total <= hi_total + 1;
        if (bus.isect_start && !start_q) edge_total <= edge_total + 1;
        if (bus.hit_valid) hv_total <= hv_total + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load_cu(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            cu_code[i] = v.code[i];
            cu_t[i]    = v.t[i];
        end
    endtask

    task automatic send(input int n, input logic sm);
        int k = 0;
        while (!bus.ray_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("ready_wait", 64'(k < 50), 64'd1);
        bus.ray_valid = 1'b1;
        bus.ray_in    = tr;
        bus.tri_count = 16'(n);
`ifdef SHADOW_ANYHIT_EN
        bus.shadow_mode = sm;
`else
        if (sm) $display("note: shadow mode not built");
`endif
        @(negedge clock);
        bus.ray_valid = 1'b0;
    endtask

    task automatic wait_hit(output int lat);
        lat = 1;
        while (!bus.hit_valid && lat < 400) begin
            @(negedge clock);
            lat++;
        end
        chk("hit_timeout", 64'(lat < 400), 64'd1);
    endtask

    task automatic take_hit(input string nm);
        bus.hit_accept = 1'b1;
        @(negedge clock);
        bus.hit_accept = 1'b0;
        chk({nm, " ready_after"}, 64'(bus.ray_ready), 64'd1);
        chk({nm, " hv_after"}, 64'(bus.hit_valid), 64'd0);
    endtask

    task automatic run_vec(input string nm, input vec_t v, input logic sm);
        int rd0;
        int e0;
        int lat;
        rd0 = rd_total;
        e0  = edge_total;
        load_cu(v);
        send(v.n, sm);
        if (v.n > 0) begin
            chk({nm, " rd_en0"}, 64'(bus.tri_rd_en), 64'd1);
            chk({nm, " addr0"}, 64'(bus.tri_addr), 64'd0);
        end
        wait_hit(lat);
        if (v.n == 0) chk({nm, " lat"}, 64'(lat <= 2), 64'd1);
        chk({nm, " found"}, 64'(bus.hit_found), 64'(v.found));
        chk({nm, " t"}, 64'(bus.hit_t), 64'(v.et));
        chk({nm, " idx"}, 64'(bus.hit_idx), 64'(v.eidx));
        chk({nm, " ray"}, 64'(bus.isect_ray == tr), 64'd1);
        chk({nm, " rd_cnt"}, 64'(rd_total - rd0), 64'(v.n));
        chk({nm, " starts"}, 64'(edge_total - e0), 64'(v.n));
        @(negedge clock);
        chk({nm, " hold_hv"}, 64'(bus.hit_valid), 64'd1);
        chk({nm, " hold_t"}, 64'(bus.hit_t), 64'(v.et));
        take_hit(nm);
    endtask

    vec_t vt [7];
    vec_t vx;

    initial begin
        int lat;
        int k;
        int e0;
        int rd0;
        int hv0;

        vt[0] = '{1, {2'd1, 2'd0, 2'd0, 2'd0},
                  {32'h08000000, 32'h0, 32'h0, 32'h0},
                  1'b1, 32'h08000000, 16'd0};
        vt[1] = '{3, {2'd1, 2'd1, 2'd1, 2'd0},
                  {32'h10000000, 32'h04000000, 32'h0C000000, 32'h0},
                  1'b1, 32'h04000000, 16'd1};
        vt[2] = '{3, {2'd1, 2'd0, 2'd1, 2'd0},
                  {32'h06000000, 32'h01000000, 32'h06000000, 32'h0},
                  1'b1, 32'h06000000, 16'd0};
        vt[3] = '{3, {2'd0, 2'd2, 2'd3, 2'd0},
                  {32'h05000000, 32'h02000000, 32'h03000000, 32'h0},
                  1'b0, 32'h0, 16'd0};
        vt[4] = '{0, {2'd1, 2'd1, 2'd1, 2'd1},
                  {32'h1, 32'h1, 32'h1, 32'h1},
                  1'b0, 32'h0, 16'd0};
        vt[5] = '{4, {2'd2, 2'd1, 2'd1, 2'd1},
                  {32'h00000001, 32'h0A000000, 32'h1FFFFFFF, 32'h09000000},
                  1'b1, 32'h09000000, 16'd3};
        vt[6] = '{2, {2'd1, 2'd1, 2'd0, 2'd0},
                  {32'h05000000, 32'h07000000, 32'h0, 32'h0},
                  1'b1, 32'h05000000, 16'd0};

        tr = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        bus.ray_valid  = 1'b0;
        bus.ray_in     = '0;
        bus.tri_count  = '0;
        bus.hit_accept = 1'b0;
`ifdef SHADOW_ANYHIT_EN
        bus.shadow_mode = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            cu_code[i] = 2'd0;
            cu_t[i]    = '0;
        end

        repeat (3) @(negedge clock);
        chk("rst ray_ready", 64'(bus.ray_ready), 64'd1);
        chk("rst hit_valid", 64'(bus.hit_valid), 64'd0);
        chk("rst start", 64'(bus.isect_start), 64'd0);
        chk("rst rd_en", 64'(bus.tri_rd_en), 64'd0);
        chk("rst found", 64'(bus.hit_found), 64'd0);
        chk("rst t", 64'(bus.hit_t), 64'd0);
        chk("rst ray", 64'(bus.isect_ray == '0), 64'd1);
        chk("rst v1", 64'(bus.isect_v1 == '0), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("v%0d", i), vt[i], 1'b0);
        end

        // reset while tri 1 of 4 is in WAIT
        vx = '{4, {2'd1, 2'd1, 2'd1, 2'd1},
               {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1, 32'h1, 16'd3};
        load_cu(vx);
        e0 = edge_total;
        send(4, 1'b0);
        k = 0;
        while (!((edge_total - e0) == 2 && !bus.isect_start) && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("rst_mid reach", 64'(k < 100), 64'd1);
        hv0 = hv_total;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid ready", 64'(bus.ray_ready), 64'd1);
        chk("rst_mid start", 64'(bus.isect_start), 64'd0);
        chk("rst_mid hv", 64'(bus.hit_valid), 64'd0);
        chk("rst_mid v1", 64'(bus.isect_v1 == '0), 64'd1);
        repeat (30) @(negedge clock);
        chk("rst_mid no_hit", 64'(hv_total - hv0), 64'd0);
        run_vec("after_rst", vt[6], 1'b0);

        // hit_accept already high when hit_valid rises
        load_cu(vt[0]);
        bus.hit_accept = 1'b1;
        send(1, 1'b0);
        wait_hit(lat);
        chk("early_acc t", 64'(bus.hit_t), 64'h08000000);
        @(negedge clock);
        bus.hit_accept = 1'b0;
        chk("early_acc hv", 64'(bus.hit_valid), 64'd0);
        chk("early_acc ready", 64'(bus.ray_ready), 64'd1);

        // ray_valid while busy must not restart the sweep
        load_cu(vt[6]);
        rd0 = rd_total;
        send(2, 1'b0);
        repeat (2) @(negedge clock);
        bus.ray_valid = 1'b1;
        bus.tri_count = 16'd5;
        repeat (4) @(negedge clock);
        bus.ray_valid = 1'b0;
        wait_hit(lat);
        chk("busy rd_cnt", 64'(rd_total - rd0), 64'd2);
        chk("busy idx", 64'(bus.hit_idx), 64'd0);
        take_hit("busy");

`ifdef SHADOW_ANYHIT_EN
        vx = '{4, {2'd0, 2'd1, 2'd1, 2'd1},
               {32'h1, 32'h0A000000, 32'h02000000, 32'h1},
               1'b1, 32'h0A000000, 16'd1};
        load_cu(vx);
        hv0 = hi_total;
        send(4, 1'b1);
        wait_hit(lat);
        chk("shadow idx", 64'(bus.hit_idx), 64'd1);
        chk("shadow t", 64'(bus.hit_t), 64'h0A000000);
        chk("shadow addr2", 64'(hi_total - hv0), 64'd0);
        take_hit("shadow");
        bus.shadow_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
